viterbi_channel: RTL and testbench
==================================

# viterbi_channel

Parametrised channel model between the convolutional encoder and the Viterbi decoder. It passes encoded symbols through a one-cycle registered path and corrupts selected bits in a controlled pattern. Corruption is either periodic bursts at a fixed offset or LFSR-randomised bursts inside each window of 2**WIN_LOG2 symbols. It also keeps injection and bad-bit statistics, and enforces an injection budget so that decoder stress tests end cleanly.

## Interface
- W, 2: symbol width (encoder output bits per symbol)
- WIN_LOG2, 4: log2 of window length in symbols
- BURST_W, 3: width of burst_len_i
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- clr_i  input  1  synchronous clear of counters, window position and FSM (to ARM if mode_i!=0)
- mode_i  input  2  0=pass-through, 1=periodic, 2=random, 3=reserved (behaves as 0)
- offset_i  input  WIN_LOG2  burst start offset in window, mode 1
- burst_len_i  input  BURST_W  symbols per burst; 0 disables injection
- err_mask_i  input  W  bits XORed into each injected symbol
- budget_i  input  16  max injected symbols; 0 = unlimited
- sym_valid_i  input  1  input symbol qualifier
- sym_i  input  W  encoded symbol
- sym_valid_o  output  1  registered sym_valid_i
- sym_o  output  W  symbol after optional corruption
- err_o  output  1  sym_o was corrupted this cycle
- inj_ct_o  output  16  injected-symbol count, saturates at 16'hFFFF
- bad_bit_ct_o  output  16  corrupted-bit count, saturates at 16'hFFFF

## Operation
- wcnt (WIN_LOG2 bits) increments on every sym_valid_i and wraps 2**WIN_LOG2-1 -> 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances only on sym_valid_i.
- Trigger trig is sampled on a valid symbol with wcnt==0:
  - mode 1: trig = offset_i.
  - mode 2: trig = lfsr[WIN_LOG2-1:0] (current value, before advance).
- Trigger comparison for that same symbol uses the newly sampled value. Trigger 0 therefore injects the first symbol of the window.
- FSM states: IDLE, ARM, WAIT, BURST, HOLD.
  - IDLE: pass-through. Go to ARM when mode_i in {1,2} and the budget is not exhausted.
  - ARM: wait for a valid symbol with wcnt==0. On it, sample trig. If wcnt==trig, inject and go to BURST (or HOLD if burst_len_i==1). Otherwise go to WAIT.
  - WAIT: on a valid symbol with wcnt==trig, inject and set bcnt=1. Go to BURST, or to HOLD if burst_len_i==1.
  - BURST: inject each valid symbol and increment bcnt. When bcnt reaches burst_len_i, go to HOLD.
  - HOLD: no injection. On a valid symbol with wcnt==0, behave exactly as ARM on that symbol.
- Window boundary: a valid symbol with wcnt==0 while in WAIT or BURST ends the burst (truncation). That symbol is then handled as in ARM, i.e. a new trigger is sampled.
- Injection: sym_o = sym_i ^ err_mask_i, err_o=1, inj_ct_o += 1. bad_bit_ct_o += popcount(err_mask_i).
- Budget exhausted: budget_i!=0 and inj_ct_o>=budget_i. No further injection; FSM goes to IDLE.
- mode_i changed to 0 or 3 in any state: the current cycle's symbol is not corrupted; FSM goes to IDLE next cycle. Counters hold.
- mode_i changed between 1 and 2 mid-window takes effect at the next trigger sample.
- burst_len_i==0 or err_mask_i==0: no symbol is counted as injected. err_o stays 0.

## Timing
- Latency is exactly 1 cycle, sym_i -> sym_o and sym_valid_i -> sym_valid_o. No backpressure.
- When sym_valid_i=0: sym_valid_o=0, err_o=0, sym_o holds its previous value. FSM, wcnt and LFSR are frozen.
- Counters update in the same cycle as err_o.
- clr_i wins over a simultaneous injection:
  - the symbol passes clean;
  - counters, wcnt and bcnt go to 0;
  - LFSR reloads LFSR_SEED.
- Reset values:
  - sym_valid_o=0, sym_o=0, err_o=0, inj_ct_o=0, bad_bit_ct_o=0;
  - FSM=IDLE, wcnt=0, LFSR=LFSR_SEED.
- Reset mid-burst aborts the burst immediately (asynchronous).

## Configuration
- VITERBI_CHAN_STATS_EN defined: bad_bit_ct_o is implemented as described.
- VITERBI_CHAN_STATS_EN undefined: bad_bit_ct_o is tied to 0 and its counter and popcount logic are removed. inj_ct_o and the budget remain.

## Test plan
- Pass-through: mode_i=0, 64 symbols with sym_valid_i=1 -> sym_o equals sym_i delayed 1 cycle, err_o never 1, inj_ct_o=0.
- Periodic: mode_i=1, offset_i=5, burst_len_i=2, err_mask_i=2'b10, 64 continuous symbols -> wcnt 5,6 corrupted in each of 4 windows. inj_ct_o=8, bad_bit_ct_o=8.
- Truncation: offset_i=15, burst_len_i=4 -> only wcnt 15 corrupted per window, then a new trigger at wcnt 0. inj_ct_o=1 per window.
- Budget: mode_i=2, burst_len_i=3, budget_i=5 -> exactly 5 injections total. FSM ends in IDLE. err_o stays 0 for the remaining symbols.
- Gapped valid: sym_valid_i=1 every 3rd cycle, mode 1 offset_i=0 -> injections on the 1st valid symbol of each 16-symbol window. LFSR and wcnt do not advance in idle cycles.
- Clear/reset mid-burst: clr_i asserted during BURST -> next symbol clean, counters 0, re-arm at wcnt 0. Async rst asserted mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/viterbi_channel_if.sv
// Symbol stream between the encoder side and the channel model.
// Carries the input symbol/qualifier and the registered, possibly corrupted output.
interface viterbi_channel_if #(
  parameter int W = 2
);
  logic         sym_valid_i;
  logic [W-1:0] sym_i;
  logic         sym_valid_o;
  logic [W-1:0] sym_o;
  logic         err_o;

  modport master (output sym_valid_i, sym_i, input sym_valid_o, sym_o, err_o);
  modport slave  (input sym_valid_i, sym_i, output sym_valid_o, sym_o, err_o);
endinterface

// File: rtl/viterbi_channel.sv
// Channel model: 1-cycle registered symbol path with periodic/LFSR burst corruption and budget.
// Define VITERBI_CHAN_STATS_EN to implement the corrupted-bit counter (bad_bit_ct_o).
//
//   state | meaning
//   IDLE  | pass-through, no corruption
//   ARM   | waiting for window start to sample a trigger
//   WAIT  | trigger sampled, waiting for wcnt == trig
//   BURST | corrupting every valid symbol until burst_len_i reached
//   HOLD  | burst done, idle until next window start
module viterbi_channel #(
  parameter int          W         = 2,
  parameter int          WIN_LOG2  = 4,
  parameter int          BURST_W   = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  viterbi_channel_if.slave    sym_bus,
  input  logic                clr_i,
  input  logic [1:0]          mode_i,
  input  logic [WIN_LOG2-1:0] offset_i,
  input  logic [BURST_W-1:0]  burst_len_i,
  input  logic [W-1:0]        err_mask_i,
  input  logic [15:0]         budget_i,
  output logic [15:0]         inj_ct_o,
  output logic [15:0]         bad_bit_ct_o
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, BURST, HOLD} state_t;

  localparam logic [BURST_W-1:0] ONE_B = 1;

  state_t              st_q, st_n;
  logic [WIN_LOG2-1:0] wcnt_q, trig_q, trig_n, trig_new;
  logic [BURST_W-1:0]  bcnt_q, bcnt_n;
  logic [BURST_W:0]    bcnt_inc;
  logic [15:0]         lfsr_q, lfsr_n, inj_ct_q;
  logic                v, mode_act, budget_done, win0, inject, do_inj;

  assign v           = sym_bus.sym_valid_i;
  assign mode_act    = (mode_i == 2'd1) || (mode_i == 2'd2);
  assign budget_done = (budget_i != 16'd0) && (inj_ct_q >= budget_i);
  assign win0        = (wcnt_q == '0);
  assign trig_new    = (mode_i == 2'd1) ? offset_i : lfsr_q[WIN_LOG2-1:0];
  assign bcnt_inc    = {1'b0, bcnt_q} + {{BURST_W{1'b0}}, 1'b1};
  assign lfsr_n      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Injection is suppressed, not the FSM walk, when the burst length or mask is zero.
  assign do_inj = inject && !clr_i && (burst_len_i != '0) && (err_mask_i != '0);

  always_comb begin
    st_n   = st_q;
    trig_n = trig_q;
    bcnt_n = bcnt_q;
    inject = 1'b0;
    if (!mode_act || budget_done) begin
      st_n = IDLE;
    end else if (st_q == IDLE) begin
      st_n = ARM;
    end else if (v) begin
      // Window start in any armed state: sample a fresh trigger, truncating any burst.
      if (win0) begin
        trig_n = trig_new;
        if (trig_new == '0) begin
          inject = 1'b1;
          bcnt_n = ONE_B;
          st_n   = (burst_len_i <= ONE_B) ? HOLD : BURST;
        end else begin
          st_n = WAIT;
        end
      end else if (st_q == WAIT && wcnt_q == trig_q) begin
        inject = 1'b1;
        bcnt_n = ONE_B;
        st_n   = (burst_len_i <= ONE_B) ? HOLD : BURST;
      end else if (st_q == BURST) begin
        inject = 1'b1;
        bcnt_n = bcnt_inc[BURST_W-1:0];
        st_n   = (bcnt_inc >= {1'b0, burst_len_i}) ? HOLD : BURST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      wcnt_q <= '0;
      trig_q <= '0;
      bcnt_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else if (clr_i) begin
      st_q   <= mode_act ? ARM : IDLE;
      wcnt_q <= '0;
      bcnt_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      st_q   <= st_n;
      trig_q <= trig_n;
      bcnt_q <= bcnt_n;
      if (v) begin
        wcnt_q <= wcnt_q + WIN_LOG2'(1);
        lfsr_q <= lfsr_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_bus.sym_valid_o <= 1'b0;
      sym_bus.sym_o       <= '0;
      sym_bus.err_o       <= 1'b0;
      inj_ct_q            <= 16'd0;
    end else begin
      sym_bus.sym_valid_o <= v;
      sym_bus.err_o       <= do_inj;
      if (v) sym_bus.sym_o <= do_inj ? (sym_bus.sym_i ^ err_mask_i) : sym_bus.sym_i;
      if (clr_i) inj_ct_q <= 16'd0;
      else if (do_inj && inj_ct_q != 16'hFFFF) inj_ct_q <= inj_ct_q + 16'd1;
    end
  end

  assign inj_ct_o = inj_ct_q;

`ifdef VITERBI_CHAN_STATS_EN
  logic [15:0] bad_ct_q;
  logic [16:0] bad_sum;

  function automatic logic [15:0] popcount(input logic [W-1:0] m);
    logic [15:0] n;
    n = 16'd0;
    for (int i = 0; i < W; i++) n = n + {15'd0, m[i]};
    return n;
  endfunction

  assign bad_sum = {1'b0, bad_ct_q} + {1'b0, popcount(err_mask_i)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        bad_ct_q <= 16'd0;
    else if (clr_i)  bad_ct_q <= 16'd0;
    else if (do_inj) bad_ct_q <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
  end

  assign bad_bit_ct_o = bad_ct_q;
`else
  assign bad_bit_ct_o = 16'd0;
`endif

endmodule

// File: tb/tb_viterbi_channel.sv
// Directed self-checking bench for viterbi_channel: pass-through, periodic, truncation,
// zero burst, LFSR budget, gapped valid, clear/mode change/async reset mid-burst.
module tb_viterbi_channel;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [3:0]  offset_i = 4'd0;
  logic [2:0]  burst_len_i = 3'd0;
  logic [1:0]  err_mask_i = 2'd0;
  logic [15:0] budget_i = 16'd0;
  logic [15:0] inj_ct_o, bad_bit_ct_o;

  int n_tests = 0;
  int n_fail  = 0;

  viterbi_channel_if #(.W(2)) sym_bus ();

  viterbi_channel #(.W(2), .WIN_LOG2(4), .BURST_W(3), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rst          (rst),
    .sym_bus      (sym_bus),
    .clr_i        (clr_i),
    .mode_i       (mode_i),
    .offset_i     (offset_i),
    .burst_len_i  (burst_len_i),
    .err_mask_i   (err_mask_i),
    .budget_i     (budget_i),
    .inj_ct_o     (inj_ct_o),
    .bad_bit_ct_o (bad_bit_ct_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] s);
    sym_bus.sym_valid_i = v;
    sym_bus.sym_i       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [3:0] off, input logic [2:0] bl,
                     input logic [1:0] mask, input logic [15:0] bud);
    mode_i = m; offset_i = off; burst_len_i = bl; err_mask_i = mask; budget_i = bud;
    clr_i = 1'b1;
    step(1'b0, 2'd0);
    clr_i = 1'b0;
  endtask

  // Continuous valid stream from wcnt 0; hit bit k marks wcnt k as corrupted.
  task automatic run_win(input string tag, input int n, input logic [1:0] mask, input logic [15:0] hit);
    logic [1:0] s;
    logic       e;
    for (int i = 0; i < n; i++) begin
      s = 2'(i * 3 + 1);
      e = hit[i % 16];
      step(1'b1, s);
      check_eq({tag, "_err"}, 32'(sym_bus.err_o), 32'(e));
      check_eq({tag, "_sym"}, 32'(sym_bus.sym_o), 32'(e ? (s ^ mask) : s));
      check_eq({tag, "_vld"}, 32'(sym_bus.sym_valid_o), 32'd1);
    end
  endtask

  function automatic logic [15:0] exp_bad(input logic [15:0] n);
`ifdef VITERBI_CHAN_STATS_EN
    return n;
`else
    return 16'd0;
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_err, n_err, late_err, k;
    logic [1:0] s;

    sym_bus.sym_valid_i = 1'b0;
    sym_bus.sym_i       = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_vld", 32'(sym_bus.sym_valid_o), 32'd0);
    check_eq("rst_sym", 32'(sym_bus.sym_o), 32'd0);
    check_eq("rst_err", 32'(sym_bus.err_o), 32'd0);
    check_eq("rst_inj", 32'(inj_ct_o), 32'd0);
    check_eq("rst_bad", 32'(bad_bit_ct_o), 32'd0);
    rst = 1'b1;
    step(1'b0, 2'd0);

    cfg(2'd0, 4'd5, 3'd2, 2'b11, 16'd0);
    run_win("pass", 64, 2'b11, 16'h0000);
    check_eq("pass_inj", 32'(inj_ct_o), 32'd0);

    cfg(2'd1, 4'd5, 3'd2, 2'b10, 16'd0);
    run_win("per", 64, 2'b10, 16'h0060);
    check_eq("per_inj", 32'(inj_ct_o), 32'd8);
    check_eq("per_bad", 32'(bad_bit_ct_o), 32'(exp_bad(16'd8)));

    cfg(2'd1, 4'd15, 3'd4, 2'b01, 16'd0);
    run_win("trunc", 64, 2'b01, 16'h8000);
    check_eq("trunc_inj", 32'(inj_ct_o), 32'd4);

    cfg(2'd1, 4'd0, 3'd0, 2'b11, 16'd0);
    run_win("blen0", 16, 2'b11, 16'h0000);
    check_eq("blen0_inj", 32'(inj_ct_o), 32'd0);

    // Seed 16'hACE1 gives first trigger 1, so the first burst covers wcnt 1..3.
    cfg(2'd2, 4'd0, 3'd3, 2'b01, 16'd5);
    first_err = -1; n_err = 0; late_err = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 2'(i));
      if (sym_bus.err_o) begin
        n_err++;
        if (first_err < 0) first_err = i;
        if (i >= 48) late_err++;
      end
    end
    check_eq("bud_first", 32'(first_err), 32'd1);
    check_eq("bud_errs", 32'(n_err), 32'd5);
    check_eq("bud_late", 32'(late_err), 32'd0);
    check_eq("bud_inj", 32'(inj_ct_o), 32'd5);
    check_eq("bud_bad", 32'(bad_bit_ct_o), 32'(exp_bad(16'd5)));

    cfg(2'd1, 4'd0, 3'd1, 2'b11, 16'd0);
    for (k = 0; k < 48; k++) begin
      s = 2'(k + 2);
      step(1'b1, s);
      check_eq("gap_err", 32'(sym_bus.err_o), 32'((k % 16) == 0));
      check_eq("gap_sym", 32'(sym_bus.sym_o), 32'(((k % 16) == 0) ? (s ^ 2'b11) : s));
      step(1'b0, 2'(k));
      check_eq("gap_idle_vld", 32'(sym_bus.sym_valid_o), 32'd0);
      check_eq("gap_idle_sym", 32'(sym_bus.sym_o), 32'(((k % 16) == 0) ? (s ^ 2'b11) : s));
      step(1'b0, 2'(k + 1));
      check_eq("gap_idle_err", 32'(sym_bus.err_o), 32'd0);
    end
    check_eq("gap_inj", 32'(inj_ct_o), 32'd3);

    cfg(2'd1, 4'd2, 3'd4, 2'b11, 16'd0);
    run_win("preclr", 3, 2'b11, 16'h0004);
    check_eq("preclr_inj", 32'(inj_ct_o), 32'd1);
    clr_i = 1'b1;
    step(1'b1, 2'd1);
    clr_i = 1'b0;
    check_eq("clr_err", 32'(sym_bus.err_o), 32'd0);
    check_eq("clr_sym", 32'(sym_bus.sym_o), 32'd1);
    check_eq("clr_inj", 32'(inj_ct_o), 32'd0);
    check_eq("clr_bad", 32'(bad_bit_ct_o), 32'd0);
    run_win("postclr", 8, 2'b11, 16'h003C);
    check_eq("postclr_inj", 32'(inj_ct_o), 32'd4);
    check_eq("postclr_bad", 32'(bad_bit_ct_o), 32'(exp_bad(16'd8)));

    cfg(2'd1, 4'd4, 3'd4, 2'b11, 16'd0);
    run_win("premode", 5, 2'b11, 16'h0010);
    mode_i = 2'd0;
    step(1'b1, 2'd2);
    check_eq("mode0_err", 32'(sym_bus.err_o), 32'd0);
    check_eq("mode0_sym", 32'(sym_bus.sym_o), 32'd2);
    check_eq("mode0_inj", 32'(inj_ct_o), 32'd1);

    cfg(2'd1, 4'd0, 3'd4, 2'b11, 16'd0);
    run_win("prerst", 2, 2'b11, 16'h0003);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_vld", 32'(sym_bus.sym_valid_o), 32'd0);
    check_eq("arst_sym", 32'(sym_bus.sym_o), 32'd0);
    check_eq("arst_err", 32'(sym_bus.err_o), 32'd0);
    check_eq("arst_inj", 32'(inj_ct_o), 32'd0);
    check_eq("arst_bad", 32'(bad_bit_ct_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
